// File: rtl/tile_feeder.sv
// Operand feeder for the 8x8 systolic tile: accepts one K-step per beat, skews lane i
// by i extra advances, then flushes zeros so the far-corner PE finishes before DONE.
module tile_feeder #(
  parameter int LANES = 8,
  parameter int DW    = 8,
  parameter int KMAX  = 8,
  parameter int KW    = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic [KW-1:0]       K_LEN,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [LANES*DW-1:0] A_IN,
  input  logic [LANES*DW-1:0] B_IN,
  output logic [LANES*DW-1:0] ROW_X,
  output logic [LANES*DW-1:0] COL_X,
  output logic                TILE_EN,
  output logic                TILE_CLR,
  output logic                BUSY,
  output logic                DONE
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN, S_DONE} state_t;

  localparam int              FLUSH_N    = 2 * (LANES - 1);
  localparam int              FW         = $clog2(FLUSH_N + 1);
  localparam logic [KW-1:0]   KMAX_C     = KW'(KMAX);
  localparam logic [FW-1:0]   FLUSH_LAST = FW'(FLUSH_N - 1);

  state_t        state_q, state_d;
  logic [KW-1:0] k_len_q, k_len_d;
  logic [KW-1:0] beat_cnt_q, beat_cnt_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic          tile_en_q, tile_en_d;
  logic          tile_clr_q, tile_clr_d;
  logic          advance_s;
  logic          flushing_s;

  assign flushing_s = (state_q == S_FLUSH);
  assign advance_s  = ((state_q == S_LOAD) && IN_VALID) || flushing_s;

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    tile_en_d   = advance_s;
    tile_clr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          if (K_LEN == '0) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_LOAD;
            k_len_d    = (K_LEN > KMAX_C) ? KMAX_C : K_LEN;
            beat_cnt_d = '0;
            tile_clr_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (IN_VALID) begin
          beat_cnt_d = beat_cnt_q + KW'(1);
          if (beat_cnt_q + KW'(1) == k_len_q) begin
            state_d     = S_FLUSH;
            flush_cnt_d = '0;
          end
        end
      end
      S_FLUSH: begin
        flush_cnt_d = flush_cnt_q + FW'(1);
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      tile_en_q   <= 1'b0;
      tile_clr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      tile_en_q   <= tile_en_d;
      tile_clr_q  <= tile_clr_d;
    end
  end

  assign IN_READY = (state_q == S_LOAD);
  assign BUSY     = (state_q != S_IDLE);
  assign DONE     = (state_q == S_DONE);
  assign TILE_EN  = tile_en_q;
  assign TILE_CLR = tile_clr_q;

  // Lane i owns a chain of i+1 stages; FLUSH injects zeros at stage 0.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [i:0][DW-1:0] row_q, row_d;
    logic [i:0][DW-1:0] col_q, col_d;

    always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (advance_s) begin
        row_d[0] = flushing_s ? '0 : A_IN[DW*i +: DW];
        col_d[0] = flushing_s ? '0 : B_IN[DW*i +: DW];
        for (int s = 1; s <= i; s++) begin
          row_d[s] = row_q[s-1];
          col_d[s] = col_q[s-1];
        end
      end else begin
        row_d = row_q;
        col_d = col_q;
      end
    end

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        row_q <= '0;
        col_q <= '0;
      end else begin
        row_q <= row_d;
        col_q <= col_d;
      end
    end

    assign ROW_X[DW*i +: DW] = row_q[i];
    assign COL_X[DW*i +: DW] = col_q[i];
  end

endmodule

// File: tb/tb_tile_feeder.sv
// Randomized bench for tile_feeder: the driver predicts each advance's edge vectors from
// the accepted beats and queues them; a negedge monitor checks them whenever TILE_EN is high.
module tb_tile_feeder;

  localparam int LANES = 8;
  localparam int DW    = 8;
  localparam int W     = LANES * DW;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic [3:0]   K_LEN;
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] A_IN, B_IN, ROW_X, COL_X;
  logic         TILE_EN, TILE_CLR, BUSY, DONE;

  tile_feeder #(.LANES(LANES), .DW(DW), .KMAX(8), .KW(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .K_LEN(K_LEN),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .A_IN(A_IN), .B_IN(B_IN),
    .ROW_X(ROW_X), .COL_X(COL_X), .TILE_EN(TILE_EN), .TILE_CLR(TILE_CLR),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] row;
    logic [W-1:0] col;
  } adv_t;

  adv_t         exp_q[$];
  int           cnt_q[$];
  logic [W-1:0] a_m[8];
  logic [W-1:0] b_m[8];
  int           checks = 0;
  int           errors = 0;
  int           en_cnt = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Edge vectors after the n-th advance of a pass: lane i shows beat n-1-i, else zero.
  task automatic push_exp(input int n, input int keff);
    adv_t e;
    int   b;
    e.row = '0;
    e.col = '0;
    for (int i = 0; i < LANES; i++) begin
      b = n - 1 - i;
      if (b >= 0 && b < keff) begin
        e.row[DW*i +: DW] = a_m[b][DW*i +: DW];
        e.col[DW*i +: DW] = b_m[b][DW*i +: DW];
      end
    end
    exp_q.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      en_cnt = 0;
    end else begin
      if (TILE_EN) begin
        en_cnt++;
        if (exp_q.size() == 0) begin
          check("tile_en_unexpected", W'(TILE_EN), W'(0));
        end else begin
          adv_t e;
          e = exp_q.pop_front();
          check("row_x", ROW_X, e.row);
          check("col_x", COL_X, e.col);
        end
      end
      if (DONE) begin
        if (cnt_q.size() == 0) begin
          check("done_unexpected", W'(DONE), W'(0));
        end else begin
          check("advance_count", W'(en_cnt), W'(cnt_q.pop_front()));
        end
        en_cnt = 0;
      end
    end
  end

  task automatic run_pass(input int klen, input int vprob, input logic [15:0] pat,
                          input int pat_len, input int dmode, input int abort_c,
                          input bit poke_start);
    int keff, sent, c, last, adv;
    bit v, in_load, in_flush, adv_now, adv_prev;
    keff = (klen > 8) ? 8 : klen;
    sent = 0;
    adv = 0;
    adv_prev = 1'b0;
    last = (keff == 0) ? -15 : 1000000;
    @(posedge CLK); #1;
    START = 1'b1;
    K_LEN = 4'(klen);
    IN_VALID = 1'b0;
    cnt_q.push_back((keff == 0) ? 0 : keff + 14);
    c = 0;
    while (1) begin
      @(posedge CLK); #1;
      c++;
      START = 1'b0;
      if (poke_start && c == 2) begin
        START = 1'b1;
        K_LEN = 4'($urandom_range(1, 15));
      end
      in_load  = (keff > 0) && (sent < keff);
      in_flush = (keff > 0) && (sent == keff) && (c >= last + 1) && (c <= last + 14);
      if (pat_len > 0) v = (c <= pat_len) ? pat[c-1] : 1'b1;
      else             v = ($urandom_range(99) < vprob);
      IN_VALID = v;
      case (dmode)
        1: for (int i = 0; i < LANES; i++) begin
             A_IN[DW*i +: DW] = 8'(i + 1);
             B_IN[DW*i +: DW] = 8'(16 + i);
           end
        2: begin A_IN = '1; B_IN = '1; end
        default: begin A_IN = {$urandom, $urandom}; B_IN = {$urandom, $urandom}; end
      endcase
      adv_now = 1'b0;
      if (in_load && v) begin
        a_m[sent] = A_IN;
        b_m[sent] = B_IN;
        sent++;
        adv++;
        adv_now = 1'b1;
        push_exp(adv, keff);
        if (sent == keff) last = c;
      end else if (in_flush) begin
        adv++;
        adv_now = 1'b1;
        push_exp(adv, keff);
      end
      if (c == abort_c) begin
        RST = 1'b0;
        #1;
        check("abort_row_x", ROW_X, W'(0));
        check("abort_col_x", COL_X, W'(0));
        check("abort_ctrl", W'({IN_READY, TILE_EN, TILE_CLR, BUSY, DONE}), W'(0));
        exp_q.delete();
        cnt_q.delete();
        IN_VALID = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        repeat (20) begin
          @(negedge CLK);
          check("no_done_after_abort", W'(DONE), W'(0));
        end
        check("idle_after_abort", W'(BUSY), W'(0));
        return;
      end
      @(negedge CLK);
      check("in_ready", W'(IN_READY), W'(in_load));
      check("busy", W'(BUSY), W'(1));
      check("tile_clr", W'(TILE_CLR), W'(c == 1 && keff > 0));
      check("tile_en", W'(TILE_EN), W'(adv_prev));
      check("done", W'(DONE), W'(c == last + 16));
      adv_prev = adv_now;
      if (c == last + 16) break;
      if (c > 3000) begin
        check("pass_timeout", W'(c), W'(last + 16));
        break;
      end
    end
    IN_VALID = 1'b0;
    @(negedge CLK);
    check("idle_busy", W'(BUSY), W'(0));
    check("idle_row_x", ROW_X, W'(0));
    check("idle_col_x", COL_X, W'(0));
  endtask

  initial begin
    RST = 1'b0;
    START = 1'b0;
    K_LEN = '0;
    IN_VALID = 1'b0;
    A_IN = '0;
    B_IN = '0;
    #12;
    check("reset_row_x", ROW_X, W'(0));
    check("reset_col_x", COL_X, W'(0));
    check("reset_ctrl", W'({IN_READY, TILE_EN, TILE_CLR, BUSY, DONE}), W'(0));
    @(posedge CLK); #1;
    RST = 1'b1;

    run_pass(2, 100, 16'h0, 0, 0, -1, 1'b0);
    run_pass(1, 100, 16'h0, 0, 1, -1, 1'b0);
    run_pass(3, 0, 16'b10_1001, 6, 0, -1, 1'b0);
    run_pass(0, 100, 16'h0, 0, 0, -1, 1'b0);
    run_pass(12, 100, 16'h0, 0, 0, -1, 1'b0);
    run_pass(5, 100, 16'h0, 0, 0, -1, 1'b1);
    run_pass(8, 100, 16'h0, 0, 2, -1, 1'b0);
    run_pass(8, 100, 16'h0, 0, 2, -1, 1'b0);
    repeat (12) begin
      run_pass($urandom_range(0, 15), $urandom_range(30, 100), 16'h0, 0, 0, -1, 1'b0);
    end
    run_pass(3, 100, 16'h0, 0, 0, 8, 1'b0);
    run_pass(4, 70, 16'h0, 0, 0, -1, 1'b0);

    repeat (4) @(negedge CLK);
    check("exp_queue_drained", W'(exp_q.size()), W'(0));
    check("count_queue_drained", W'(cnt_q.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_feeder.md
Name: tile_feeder

Overview:
- Streaming front end that drives the 8x8 systolic tile's west (row) and north (column) edge inputs.
- Accepts one K-step per beat: an 8-lane A column vector and an 8-lane B row vector, over a valid/ready handshake.
- Applies the diagonal skew: lane i is delayed i extra advances. Generates the tile's EN, flushes zeros so the last product reaches the far-corner PE, then pulses DONE.
- Sits between the operand buffers and tile8x8; the tile's edge inputs connect directly to ROW_X/COL_X lanes.

Parameters:
- LANES, 8, number of rows/columns of the tile (lanes per vector).
- DW, 8, operand width per lane.
- KMAX, 8, max K-steps per pass; fixed by the 19-bit tile accumulator headroom (16-bit products x 8).
- KW, 4, width of K_LEN (holds 0..KMAX).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous reset, active-low.
- START  in  1  begin a pass; sampled only in IDLE.
- K_LEN  in  KW  number of K-steps for the pass; sampled with START.
- IN_VALID  in  1  A_IN/B_IN hold a valid beat.
- IN_READY  out  1  feeder accepts a beat this cycle.
- A_IN  in  LANES*DW  lane i = bits [DW*i+DW-1 : DW*i] = A[i][k].
- B_IN  in  LANES*DW  lane j = B[k][j].
- ROW_X  out  LANES*DW  lane i drives tile row-edge input i.
- COL_X  out  LANES*DW  lane j drives tile column-edge input j.
- TILE_EN  out  1  tile enable.
- TILE_CLR  out  1  one-cycle accumulator-clear request at pass start.
- BUSY  out  1  state != IDLE.
- DONE  out  1  one-cycle pulse: all 64 accumulators final.

Behaviour:
- Reset (RST low, async): state=IDLE; all skew registers, ROW_X, COL_X = 0; IN_READY, TILE_EN, TILE_CLR, BUSY, DONE = 0; K counter = 0. Reset mid-pass aborts with no DONE.
- States: IDLE -> LOAD -> FLUSH -> DRAIN -> DONE -> IDLE.
- IDLE:
  - START=1 with K_LEN>=1: latch min(K_LEN,KMAX), go to LOAD, TILE_CLR=1 for the next cycle only.
  - START=1 with K_LEN=0: go directly to DONE. No TILE_CLR, no TILE_EN.
- LOAD:
  - IN_READY=1, combinational from state.
  - A beat is accepted when IN_VALID && IN_READY.
  - After the K-th accepted beat, go to FLUSH.
  - If IN_VALID=0, nothing advances (bubble); the skew pipeline and tile freeze.
- FLUSH: exactly 2*(LANES-1)=14 advances with zero data injected, one per cycle unconditionally, then DRAIN.
- DRAIN: one cycle with no advance, then DONE.
- DONE: DONE=1 for one cycle, then IDLE.
- START outside IDLE is ignored.
- advance = (LOAD && IN_VALID) || FLUSH.
- Skew: per lane i, a chain of i+1 registers (stage 0..i). On advance, stage 0 loads the input lane (or 0 in FLUSH) and stage s loads stage s-1. No advance: hold. Output lane i = stage i.
  - Latency from acceptance to appearance on lane i = i+1 advances.
  - Identical structure for ROW_X (from A_IN) and COL_X (from B_IN).
- TILE_EN is a register equal to advance from the previous cycle. The tile samples the freshly loaded edge values exactly once per advance.
- No arithmetic in the feeder; data passes bit-exact. K_LEN > KMAX is clamped to KMAX.
- Continuous-valid timing (START at cycle 0):
  - TILE_CLR cycle 1.
  - IN_READY cycles 1..K.
  - FLUSH cycles K+1..K+14.
  - DRAIN cycle K+15.
  - DONE cycle K+16.
  - TILE_EN cycles 2..K+15 (K+14 cycles).

Test Plan:
- Reset mid-pass: RST low during FLUSH -> all outputs 0 immediately (async); then IDLE, no DONE pulse.
- START, K_LEN=2, IN_VALID held 1 -> IN_READY cycles 1-2; TILE_EN high cycles 2-17 (16 cycles); DONE only at cycle 18; BUSY cycles 1-18.
- K_LEN=1, A_IN lane i = i+1, B_IN lane j = 0x10+j -> ROW_X lane i equals i+1 for exactly one advance, i+1 advances after acceptance; COL_X lane 7 = 0x17 at FLUSH advance 7; all lanes 0 otherwise.
- K_LEN=3, IN_VALID toggling 1,0,0,1,0,1 -> exactly 3 beats accepted; ROW_X/COL_X/TILE_EN frozen (TILE_EN=0) in the cycle after each bubble; FLUSH count still 14.
- End-to-end with tile8x8: K=8, A and B all 0xFF (unsigned) -> every Y_ij = 8*65025 = 520200 (fits 19 bits) at DONE; a second pass after TILE_CLR restarts from 0.
- Edge cases: START with K_LEN=0 -> DONE at cycle 1, TILE_EN never high. K_LEN=12 -> clamped, exactly 8 beats accepted. START pulsed during LOAD -> ignored, K count unchanged.
